pipe_fwd_chain: RTL and testbench
=================================

// Module: pipe_fwd_chain
// PURPOSE
// Parametrised N-stage pipeline-register chain with per-stage valid bits and stall/flush control.
// Adds a built-in youngest-first forwarding lookup (2 read ports) and a sticky halt latch.
// Replaces hand-built if_id/id_ex/ex_mem/mem_wb latches and forwarding glue in the processor datapath.
// Stage 0 is youngest (entry); stage STAGES-1 is oldest (writeback).
// PARAMETERS
// STAGES    4   number of pipeline stages, >=2
// DATA_W    32  result payload width
// TAG_W     5   destination-register tag width; tag 0 is never written and never forwarded
// RDY_STAGE 2   stage at which res_data is captured, 1..STAGES-1
// SW        $clog2(STAGES)  stage-index width (derived, localparam)
// PORTS
// CLK         in   1       clock, rising edge
// nRST        in   1       asynchronous, active-low reset
// advance     in   1       global step enable (ihit/dhit qualified); 0 = whole chain holds
// in_valid    in   1       new entry presented to stage 0
// in_dest     in   TAG_W   destination tag of new entry
// in_wen      in   1       entry writes a register
// in_rdy      in   1       in_data already final at entry (e.g. LUI, JAL link)
// in_data     in   DATA_W  early payload
// in_halt     in   1       entry is HALT
// in_ready    out  1       stage 0 accepts this cycle
// stall_en    in   1       freeze stages 0..stall_at, insert bubble above
// stall_at    in   SW      highest frozen stage
// flush_en    in   1       kill stages 0..flush_upto
// flush_upto  in   SW      highest killed stage
// res_wr      in   1       res_data replaces payload on entry into RDY_STAGE
// res_data    in   DATA_W  late result (ALU/memory)
// qa_tag      in   TAG_W   forwarding query A (rs)
// qa_hit      out  1       ready match found for A
// qa_pend     out  1       youngest match for A not yet ready (hazard)
// qa_data     out  DATA_W  forwarded data for A (0 when !qa_hit)
// qb_*        -    -       identical port set for query B (rt)
// stage_valid out  STAGES  per-stage valid bits
// out_valid   out  1       stage STAGES-1 valid
// out_dest, out_wen, out_data  out  TAG_W/1/DATA_W  writeback fields of oldest stage
// halt        out  1       sticky halt
// retired     out  32      retired-entry count, saturating at 32'hFFFF_FFFF
// BEHAVIOUR
// - Reset (async): all valid=0, payloads/tags/flags=0, halt=0, retired=0; in_ready=0 while nRST=0.
// - advance=0: every stage holds; flush still applies (flush is not gated by advance).
// - advance=1, no stall: stage i <= stage i-1; stage 0 <= input if in_valid&&in_ready, else bubble.
// - Entering RDY_STAGE: if res_wr, data<=res_data and rdy<=1; else rdy passes through.
// - stall_en: stages 0..stall_at hold, stage stall_at+1 gets bubble (valid=0), higher stages advance.
//   in_ready=0. stall_at=STAGES-1 behaves as advance=0.
// - flush_en: stages 0..flush_upto valid<=0 on the edge. This overrides hold/advance for those stages.
//   Flush beats stall on the same stage.
// - in_ready = advance && !stall_en && !halt.
// - Forwarding, combinational: scan stage 0 upward, pick first with valid && wen && dest==tag && tag!=0.
//   Match rdy: hit=1, data=payload. Not rdy: pend=1, hit=0.
//   Older matches are ignored once a younger one is found. tag 0: hit=pend=0.
// - Retire: oldest stage valid && advance -> retired+1, saturating.
//   If that entry has halt flag, halt<=1 on that edge.
// - halt is sticky until reset. Once set, no entries are accepted and in-flight entries drain normally.
// - Outputs of the oldest stage are registered values; the pipeline fill latency is STAGES cycles.
// TESTING
// - Reset, then 6 entries dest=1..6 data=10..60 rdy=1, advance=1 -> out_dest 1..6 from cycle 4; retired=6.
// - Entry A dest=3 rdy=0, res_wr res_data=0xBEEF at RDY_STAGE; qa_tag=3 while A is in stage 1 -> qa_pend=1.
//   Once A is in stage 2 -> qa_hit=1, qa_data=0xBEEF.
// - Stages 1 and 3 both dest=5 (data 0x11 / 0x33), qb_tag=5 -> qb_data=0x11. qa_tag=0 with dest 0 present -> no hit.
// - stall_en stall_at=1 for 2 cycles -> stages 0,1 hold, stage 2 valid=0 each cycle, in_ready=0; no entry lost.
// - flush_en flush_upto=1 together with stall_at=1 -> stages 0,1 invalid next cycle, stages 2,3 advance.
// - HALT entry followed by 3 entries -> halt rises on the edge it retires, in_ready=0 thereafter.
//   Assert nRST mid-run -> every output 0 immediately.

Source files
------------

// File: rtl/pipe_fwd_chain.sv
// N-stage pipeline register chain with stall/flush control, two youngest-first
// forwarding lookups, a sticky halt latch and a saturating retired-entry counter.
module pipe_fwd_chain #(
  parameter int STAGES    = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 5,
  parameter int RDY_STAGE = 2,
  localparam int SW       = $clog2(STAGES)
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                advance,
  input  logic                in_valid,
  input  logic [TAG_W-1:0]    in_dest,
  input  logic                in_wen,
  input  logic                in_rdy,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_halt,
  output logic                in_ready,
  input  logic                stall_en,
  input  logic [SW-1:0]       stall_at,
  input  logic                flush_en,
  input  logic [SW-1:0]       flush_upto,
  input  logic                res_wr,
  input  logic [DATA_W-1:0]   res_data,
  input  logic [TAG_W-1:0]    qa_tag,
  output logic                qa_hit,
  output logic                qa_pend,
  output logic [DATA_W-1:0]   qa_data,
  input  logic [TAG_W-1:0]    qb_tag,
  output logic                qb_hit,
  output logic                qb_pend,
  output logic [DATA_W-1:0]   qb_data,
  output logic [STAGES-1:0]   stage_valid,
  output logic                out_valid,
  output logic [TAG_W-1:0]    out_dest,
  output logic                out_wen,
  output logic [DATA_W-1:0]   out_data,
  output logic                halt,
  output logic [31:0]         retired
);

  logic [STAGES-1:0] v_q, wen_q, rdy_q, hlt_q;
  logic [TAG_W-1:0]  dest_q [STAGES];
  logic [DATA_W-1:0] data_q [STAGES];
  logic              halt_q;
  logic [31:0]       retired_q;

  logic [STAGES-1:0] frz, bub, kill;
  logic              take, ret;

  typedef struct packed {
    logic              hit;
    logic              pend;
    logic [DATA_W-1:0] data;
  } fwd_t;

  fwd_t fa, fb;

  // Per-stage control: frozen (hold), bubble insertion, and flush kill.
  always_comb begin
    frz  = '0;
    bub  = '0;
    kill = '0;
    for (int i = 0; i < STAGES; i++) begin
      frz[i]  = !advance || (stall_en && (i <= int'(stall_at)));
      bub[i]  = advance && stall_en && (i == int'(stall_at) + 1);
      kill[i] = flush_en && (i <= int'(flush_upto));
    end
  end

  assign in_ready = nRST && advance && !stall_en && !halt_q;
  assign take     = in_valid && in_ready;
  assign ret      = v_q[STAGES-1] && !frz[STAGES-1];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      v_q       <= '0;
      wen_q     <= '0;
      rdy_q     <= '0;
      hlt_q     <= '0;
      halt_q    <= 1'b0;
      retired_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (kill[0]) begin
        v_q[0] <= 1'b0;
      end else if (!frz[0]) begin
        v_q[0]    <= take;
        dest_q[0] <= in_dest;
        wen_q[0]  <= in_wen;
        rdy_q[0]  <= in_rdy;
        data_q[0] <= in_data;
        hlt_q[0]  <= in_halt;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (kill[i] || bub[i]) begin
          v_q[i] <= 1'b0;
        end else if (!frz[i]) begin
          v_q[i]    <= v_q[i-1];
          dest_q[i] <= dest_q[i-1];
          wen_q[i]  <= wen_q[i-1];
          hlt_q[i]  <= hlt_q[i-1];
          // The late result is merged as the entry moves into the capture stage.
          if (i == RDY_STAGE && res_wr) begin
            data_q[i] <= res_data;
            rdy_q[i]  <= 1'b1;
          end else begin
            data_q[i] <= data_q[i-1];
            rdy_q[i]  <= rdy_q[i-1];
          end
        end
      end
      if (ret && retired_q != 32'hFFFF_FFFF) retired_q <= retired_q + 32'd1;
      if (ret && hlt_q[STAGES-1]) halt_q <= 1'b1;
    end
  end

  // Walk oldest to youngest so the youngest matching stage overwrites the result.
  function automatic fwd_t lookup(input logic [TAG_W-1:0] tag);
    fwd_t r;
    r = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (v_q[i] && wen_q[i] && dest_q[i] == tag && tag != '0) begin
        r.hit  = rdy_q[i];
        r.pend = !rdy_q[i];
        r.data = rdy_q[i] ? data_q[i] : '0;
      end
    end
    return r;
  endfunction

  always_comb begin
    fa = lookup(qa_tag);
    fb = lookup(qb_tag);
  end

  assign qa_hit      = fa.hit;
  assign qa_pend     = fa.pend;
  assign qa_data     = fa.data;
  assign qb_hit      = fb.hit;
  assign qb_pend     = fb.pend;
  assign qb_data     = fb.data;
  assign stage_valid = v_q;
  assign out_valid   = v_q[STAGES-1];
  assign out_dest    = dest_q[STAGES-1];
  assign out_wen     = wen_q[STAGES-1];
  assign out_data    = data_q[STAGES-1];
  assign halt        = halt_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_pipe_fwd_chain.sv
// Scoreboard bench for pipe_fwd_chain: directed entries push expected writebacks,
// a negedge monitor pops them as the oldest stage retires.
module tb_pipe_fwd_chain;
  localparam int STAGES = 4;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;
  localparam int SW     = 2;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              advance = 1'b1;
  logic              in_valid = 1'b0;
  logic [TAG_W-1:0]  in_dest = '0;
  logic              in_wen = 1'b0;
  logic              in_rdy = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_halt = 1'b0;
  logic              in_ready;
  logic              stall_en = 1'b0;
  logic [SW-1:0]     stall_at = '0;
  logic              flush_en = 1'b0;
  logic [SW-1:0]     flush_upto = '0;
  logic              res_wr = 1'b0;
  logic [DATA_W-1:0] res_data = '0;
  logic [TAG_W-1:0]  qa_tag = '0;
  logic              qa_hit, qa_pend;
  logic [DATA_W-1:0] qa_data;
  logic [TAG_W-1:0]  qb_tag = '0;
  logic              qb_hit, qb_pend;
  logic [DATA_W-1:0] qb_data;
  logic [STAGES-1:0] stage_valid;
  logic              out_valid, out_wen, halt;
  logic [TAG_W-1:0]  out_dest;
  logic [DATA_W-1:0] out_data;
  logic [31:0]       retired;

  typedef struct {
    logic [TAG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  always #5 CLK = ~CLK;

  pipe_fwd_chain #(.STAGES(STAGES), .DATA_W(DATA_W), .TAG_W(TAG_W), .RDY_STAGE(2)) dut (
    .CLK(CLK), .nRST(nRST), .advance(advance),
    .in_valid(in_valid), .in_dest(in_dest), .in_wen(in_wen), .in_rdy(in_rdy),
    .in_data(in_data), .in_halt(in_halt), .in_ready(in_ready),
    .stall_en(stall_en), .stall_at(stall_at), .flush_en(flush_en), .flush_upto(flush_upto),
    .res_wr(res_wr), .res_data(res_data),
    .qa_tag(qa_tag), .qa_hit(qa_hit), .qa_pend(qa_pend), .qa_data(qa_data),
    .qb_tag(qb_tag), .qb_hit(qb_hit), .qb_pend(qb_pend), .qb_data(qb_data),
    .stage_valid(stage_valid), .out_valid(out_valid), .out_dest(out_dest),
    .out_wen(out_wen), .out_data(out_data), .halt(halt), .retired(retired)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic v, input logic [TAG_W-1:0] d,
                               input logic [DATA_W-1:0] x, input logic r, input logic h);
    in_valid = v;
    in_dest  = d;
    in_data  = x;
    in_rdy   = r;
    in_halt  = h;
    in_wen   = 1'b1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int n);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  // Retirement monitor: the oldest entry leaves whenever it is valid and not frozen.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (nRST && out_valid && advance && !(stall_en && stall_at == 2'd3)) begin
        if (sb.size() == 0) begin
          total++;
          $display("[TB] FAIL unexpected_retire: got dest %0d, expected no entry", out_dest);
        end else begin
          e = sb.pop_front();
          checkOutput("ret_dest", 32'(out_dest), 32'(e.dest));
          checkOutput("ret_data", out_data, e.data);
        end
      end
    end
  end

  initial begin
    #2;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_stage_valid", 32'(stage_valid), 32'd0);
    checkOutput("rst_halt", 32'(halt), 32'd0);
    checkOutput("rst_retired", retired, 32'd0);
    nRST = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Six ready entries streaming through.
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 5'(k), 32'(k * 10), 1'b1, 1'b0);
      sb.push_back('{5'(k), 32'(k * 10)});
      tick();
      checkOutput("fill_out_valid", 32'(out_valid), 32'(k >= 4));
      if (k >= 4) checkOutput("fill_out_dest", 32'(out_dest), 32'(k - 3));
    end
    drain(4);
    checkOutput("fill_retired", retired, 32'd6);

    // Late result captured at the ready stage.
    applyStimulus(1'b1, 5'd3, 32'd0, 1'b0, 1'b0);
    sb.push_back('{5'd3, 32'h0000_BEEF});
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    qa_tag = 5'd3;
    #1;
    checkOutput("fwd_pend_s0", 32'(qa_pend), 32'd1);
    tick();
    checkOutput("fwd_pend_s1", 32'(qa_pend), 32'd1);
    checkOutput("fwd_nohit_s1", 32'(qa_hit), 32'd0);
    res_wr = 1'b1;
    res_data = 32'h0000_BEEF;
    tick();
    res_wr = 1'b0;
    #1;
    checkOutput("fwd_hit_s2", 32'(qa_hit), 32'd1);
    checkOutput("fwd_data_s2", qa_data, 32'h0000_BEEF);
    checkOutput("fwd_nopend_s2", 32'(qa_pend), 32'd0);
    qa_tag = '0;
    drain(4);

    // Youngest match wins; tag 0 never forwards.
    applyStimulus(1'b1, 5'd5, 32'h33, 1'b1, 1'b0);
    sb.push_back('{5'd5, 32'h33});
    tick();
    applyStimulus(1'b1, 5'd0, 32'h77, 1'b1, 1'b0);
    sb.push_back('{5'd0, 32'h77});
    tick();
    applyStimulus(1'b1, 5'd5, 32'h11, 1'b1, 1'b0);
    sb.push_back('{5'd5, 32'h11});
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    qb_tag = 5'd5;
    qa_tag = 5'd0;
    #1;
    checkOutput("young_hit", 32'(qb_hit), 32'd1);
    checkOutput("young_data", qb_data, 32'h11);
    checkOutput("tag0_hit", 32'(qa_hit), 32'd0);
    checkOutput("tag0_pend", 32'(qa_pend), 32'd0);
    qa_tag = 5'd9;
    #1;
    checkOutput("miss_hit", 32'(qa_hit), 32'd0);
    qa_tag = '0;
    qb_tag = '0;
    drain(4);

    // Stall below stage 2 for two cycles.
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 5'(10 + k), 32'(256 + k), 1'b1, 1'b0);
      sb.push_back('{5'(10 + k), 32'(256 + k)});
      tick();
    end
    applyStimulus(1'b1, 5'd15, 32'h105, 1'b1, 1'b0);
    stall_en = 1'b1;
    stall_at = 2'd1;
    #1;
    checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("stall_valid_1", 32'(stage_valid), 32'b1011);
    checkOutput("stall_in_ready_1", 32'(in_ready), 32'd0);
    tick();
    checkOutput("stall_valid_2", 32'(stage_valid), 32'b0011);
    stall_en = 1'b0;
    #1;
    checkOutput("unstall_in_ready", 32'(in_ready), 32'd1);
    sb.push_back('{5'd15, 32'h105});
    tick();
    checkOutput("unstall_valid", 32'(stage_valid), 32'b0111);
    drain(5);

    // Flush and stall on the same stages.
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 5'(20 + k), 32'(512 + k), 1'b1, 1'b0);
      if (k <= 2) sb.push_back('{5'(20 + k), 32'(512 + k)});
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    stall_en = 1'b1;
    stall_at = 2'd1;
    flush_en = 1'b1;
    flush_upto = 2'd1;
    tick();
    stall_en = 1'b0;
    flush_en = 1'b0;
    checkOutput("flush_valid", 32'(stage_valid), 32'b1000);
    checkOutput("flush_out_dest", 32'(out_dest), 32'd22);
    drain(3);

    // Halt entry followed by three more.
    applyStimulus(1'b1, 5'd7, 32'h70, 1'b1, 1'b1);
    sb.push_back('{5'd7, 32'h70});
    tick();
    for (int k = 8; k <= 10; k++) begin
      applyStimulus(1'b1, 5'(k), 32'(k * 16), 1'b1, 1'b0);
      sb.push_back('{5'(k), 32'(k * 16)});
      tick();
    end
    checkOutput("halt_before", 32'(halt), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("halt_set", 32'(halt), 32'd1);
    checkOutput("halt_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 5'd31, 32'h31F, 1'b1, 1'b0);
    qa_tag = 5'd9;
    qb_tag = 5'd10;
    tick();
    checkOutput("halt_in_ready_2", 32'(in_ready), 32'd0);
    checkOutput("halt_retired", retired, 32'd19);
    checkOutput("inflight_qa_hit", 32'(qa_hit), 32'd1);
    checkOutput("inflight_qa_data", qa_data, 32'h90);
    checkOutput("inflight_qb_hit", 32'(qb_hit), 32'd1);

    // Asynchronous reset mid-run with entries in flight.
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    nRST = 1'b0;
    #1;
    sb.delete();
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("mid_rst_valid", 32'(stage_valid), 32'd0);
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_out_dest", 32'(out_dest), 32'd0);
    checkOutput("mid_rst_out_wen", 32'(out_wen), 32'd0);
    checkOutput("mid_rst_out_data", out_data, 32'd0);
    checkOutput("mid_rst_halt", 32'(halt), 32'd0);
    checkOutput("mid_rst_retired", retired, 32'd0);
    checkOutput("mid_rst_qa_hit", 32'(qa_hit), 32'd0);
    checkOutput("mid_rst_qa_data", qa_data, 32'd0);
    checkOutput("mid_rst_qb_hit", 32'(qb_hit), 32'd0);
    #2;
    nRST = 1'b1;
    qa_tag = '0;
    qb_tag = '0;
    applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 1'b0);
    #1;
    checkOutput("rerun_in_ready", 32'(in_ready), 32'd1);
    sb.push_back('{5'd2, 32'h22});
    tick();
    drain(5);
    checkOutput("rerun_retired", retired, 32'd1);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
